stage_id: RTL and testbench

Instruction-decode stage of the RVX in-order pipeline, directly downstream of the fetch stage. Captures the 65-bit fetch bundle {bp_taken, pc, inst} into a single pipeline slot. Decodes the RV32I instruction, generates the immediate and reads operands, with write-back bypass applied at read time. Presents one decoded instruction per cycle to execute through a valid/ready handshake, handles load-use hazards, and flushes on kill.

---
 rtl/rvx_pkg.sv | 46 ++++
 rtl/stage_id_if.sv | 43 ++++
 rtl/id_decoder.sv | 81 ++++++++
 rtl/stage_id.sv | 101 ++++++++++
 tb/tb_stage_id.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvx_pkg.sv
// Shared RVX definitions: RV32I opcodes, execute-class encodings, fetch-bundle
// field offsets and the decode-slot record used by the ID stage.
package rvx_pkg;

   localparam int BP_BIT = 64;
   localparam int PC_MSB = 63;
   localparam int PC_LSB = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      CLS_ALU    = 4'd0,
      CLS_LUI    = 4'd1,
      CLS_AUIPC  = 4'd2,
      CLS_JAL    = 4'd3,
      CLS_JALR   = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_LOAD   = 4'd6,
      CLS_STORE  = 4'd7,
      CLS_FENCE  = 4'd8,
      CLS_SYSTEM = 4'd9
   } ex_class_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      ex_class_e   cls;
      logic [3:0]  alu_op;
      logic        bp_taken;
      logic        illegal;
   } ex_slot_t;

endpackage

// File: rtl/stage_id_if.sv
// Fetch, register-file, write-back and execute signals of the ID stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and a producer holding valid keeps its data stable.
interface stage_id_if;
   logic        kill;
   logic        if_valid;
   logic [64:0] if_inst;
   logic        if_ready;
   logic [4:0]  rf_rs1_addr;
   logic [4:0]  rf_rs2_addr;
   logic [31:0] rf_rs1_data;
   logic [31:0] rf_rs2_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_class;
   logic [3:0]  ex_alu_op;
   logic        ex_bp_taken;
   logic        ex_illegal;

   modport slave (
      input  kill, if_valid, if_inst, rf_rs1_data, rf_rs2_data,
             wb_we, wb_rd, wb_data, ex_ready,
      output if_ready, rf_rs1_addr, rf_rs2_addr, ex_valid, ex_pc,
             ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_class, ex_alu_op,
             ex_bp_taken, ex_illegal
   );

   modport master (
      output kill, if_valid, if_inst, rf_rs1_data, rf_rs2_data,
             wb_we, wb_rd, wb_data, ex_ready,
      input  if_ready, rf_rs1_addr, rf_rs2_addr, ex_valid, ex_pc,
             ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_class, ex_alu_op,
             ex_bp_taken, ex_illegal
   );
endinterface

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: class, register fields, operand usage,
// sign-extended immediate, ALU op and illegal-opcode flag.
module id_decoder
   import rvx_pkg::*;
(
   input  logic [31:0] inst_i,
   output ex_class_e   cls_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic        uses_rs1_o,
   output logic        uses_rs2_o,
   output logic [31:0] imm_o,
   output logic [3:0]  alu_op_o,
   output logic        illegal_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign rs1_o  = inst_i[19:15];
   assign rs2_o  = inst_i[24:20];

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   // Illegal opcodes decode as ALU, so they still count as reading rs1.
   assign uses_rs1_o = !(cls_o inside {CLS_LUI, CLS_AUIPC, CLS_JAL});

   always_comb begin
      cls_o      = CLS_ALU;
      rd_o       = inst_i[11:7];
      imm_o      = '0;
      alu_op_o   = '0;
      illegal_o  = 1'b0;
      uses_rs2_o = 1'b0;
      case (opcode)
         OPC_OP: begin
            alu_op_o   = {inst_i[30], funct3};
            uses_rs2_o = 1'b1;
         end
         OPC_OPIMM: begin
            imm_o    = imm_i;
            alu_op_o = {(funct3 == 3'b101) & inst_i[30], funct3};
         end
         OPC_LUI:    begin cls_o = CLS_LUI;    imm_o = imm_u; end
         OPC_AUIPC:  begin cls_o = CLS_AUIPC;  imm_o = imm_u; end
         OPC_JAL:    begin cls_o = CLS_JAL;    imm_o = imm_j; end
         OPC_JALR:   begin cls_o = CLS_JALR;   imm_o = imm_i; end
         OPC_LOAD:   begin cls_o = CLS_LOAD;   imm_o = imm_i; end
         OPC_SYSTEM: begin cls_o = CLS_SYSTEM; imm_o = imm_i; end
         OPC_BRANCH: begin
            cls_o      = CLS_BRANCH;
            imm_o      = imm_b;
            rd_o       = '0;
            uses_rs2_o = 1'b1;
         end
         OPC_STORE: begin
            cls_o      = CLS_STORE;
            imm_o      = imm_s;
            rd_o       = '0;
            uses_rs2_o = 1'b1;
         end
         OPC_FENCE: begin
            cls_o = CLS_FENCE;
            rd_o  = '0;
         end
         default: begin
            illegal_o = 1'b1;
            rd_o      = '0;
         end
      endcase
   end

endmodule

// File: rtl/stage_id.sv
// RVX instruction-decode stage: one-entry slot between fetch and execute with
// load-use stall, write-back bypass at capture time and kill flush.
module stage_id
   import rvx_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic        clk,
   input logic        reset,
   stage_id_if.slave  bus
);

   logic [31:0]     inst;
   ex_class_e       dec_cls;
   logic [4:0]      dec_rd, dec_rs1, dec_rs2;
   logic            dec_uses_rs1, dec_uses_rs2, dec_illegal;
   logic [31:0]     dec_imm;
   logic [3:0]      dec_alu_op;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            hazard, ready, accept;
   ex_slot_t        slot_q, slot_d;
   logic            valid_q, valid_d;

   assign inst = bus.if_inst[31:0];

   id_decoder u_dec (
      .inst_i     (inst),
      .cls_o      (dec_cls),
      .rd_o       (dec_rd),
      .rs1_o      (dec_rs1),
      .rs2_o      (dec_rs2),
      .uses_rs1_o (dec_uses_rs1),
      .uses_rs2_o (dec_uses_rs2),
      .imm_o      (dec_imm),
      .alu_op_o   (dec_alu_op),
      .illegal_o  (dec_illegal)
   );

   assign bus.rf_rs1_addr = dec_rs1;
   assign bus.rf_rs2_addr = dec_rs2;

   // Bypass only at capture; a held slot keeps the value it was loaded with.
   always_comb begin
      rs1_val = bus.rf_rs1_data;
      rs2_val = bus.rf_rs2_data;
      if (dec_rs1 == 5'd0)                             rs1_val = '0;
      else if (bus.wb_we && (bus.wb_rd == dec_rs1))    rs1_val = bus.wb_data;
      if (dec_rs2 == 5'd0)                             rs2_val = '0;
      else if (bus.wb_we && (bus.wb_rd == dec_rs2))    rs2_val = bus.wb_data;
   end

   assign hazard = valid_q && (slot_q.cls == CLS_LOAD) && (slot_q.rd != 5'd0) &&
                   ((dec_uses_rs1 && (dec_rs1 == slot_q.rd)) ||
                    (dec_uses_rs2 && (dec_rs2 == slot_q.rd)));
   assign ready  = !reset && (!valid_q || bus.ex_ready) && !hazard;
   assign accept = bus.if_valid && ready && !bus.kill && (inst != 32'd0);
   assign bus.if_ready = ready;

   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      if (bus.kill) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d         = 1'b1;
         slot_d.pc       = bus.if_inst[PC_MSB:PC_LSB];
         slot_d.rs1_val  = rs1_val;
         slot_d.rs2_val  = rs2_val;
         slot_d.imm      = dec_imm;
         slot_d.rd       = dec_rd;
         slot_d.cls      = dec_cls;
         slot_d.alu_op   = dec_alu_op;
         slot_d.bp_taken = bus.if_inst[BP_BIT];
         slot_d.illegal  = dec_illegal;
      end else if (bus.ex_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ex_valid    = valid_q;
   assign bus.ex_pc       = slot_q.pc;
   assign bus.ex_rs1_val  = slot_q.rs1_val;
   assign bus.ex_rs2_val  = slot_q.rs2_val;
   assign bus.ex_imm      = slot_q.imm;
   assign bus.ex_rd       = slot_q.rd;
   assign bus.ex_class    = slot_q.cls;
   assign bus.ex_alu_op   = slot_q.alu_op;
   assign bus.ex_bp_taken = slot_q.bp_taken;
   assign bus.ex_illegal  = slot_q.illegal;

endmodule

// File: tb/tb_stage_id.sv
// Bench for stage_id: directed scenarios plus a randomized run against a
// transaction-level model of the decode slot.
module tb_stage_id;

   typedef struct packed {
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        ill;
      logic        u1;
      logic        u2;
   } tdec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [31:0] exp_q[$];
   logic [6:0]  ops [0:12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                               7'h03, 7'h03, 7'h23, 7'h0F, 7'h73, 7'h7F};

   stage_id_if bus ();

   stage_id #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   // ---------------- reference model helpers ----------------
   function automatic tdec_t ref_decode(input logic [31:0] w);
      tdec_t r;
      logic [31:0] imm_i;
      r     = '0;
      r.rd  = w[11:7];
      r.u1  = 1'b1;
      imm_i = {{20{w[31]}}, w[31:20]};
      case (w[6:0])
         7'h33: begin r.alu = {w[30], w[14:12]}; r.u2 = 1'b1; end
         7'h13: begin r.imm = imm_i; r.alu = {(w[14:12] == 3'd5) ? w[30] : 1'b0, w[14:12]}; end
         7'h37: begin r.cls = 4'd1; r.imm = {w[31:12], 12'h000}; r.u1 = 1'b0; end
         7'h17: begin r.cls = 4'd2; r.imm = {w[31:12], 12'h000}; r.u1 = 1'b0; end
         7'h6F: begin r.cls = 4'd3; r.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; r.u1 = 1'b0; end
         7'h67: begin r.cls = 4'd4; r.imm = imm_i; end
         7'h63: begin r.cls = 4'd5; r.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; r.rd = 0; r.u2 = 1'b1; end
         7'h03: begin r.cls = 4'd6; r.imm = imm_i; end
         7'h23: begin r.cls = 4'd7; r.imm = {{20{w[31]}}, w[31:25], w[11:7]}; r.rd = 0; r.u2 = 1'b1; end
         7'h0F: begin r.cls = 4'd8; r.rd = 0; end
         7'h73: begin r.cls = 4'd9; r.imm = imm_i; end
         default: begin r.ill = 1'b1; r.rd = 0; end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf,
                                                input logic we, input logic [4:0] wrd,
                                                input logic [31:0] wdata);
      if (rs == 5'd0) return 32'd0;
      if (we && (wrd == rs)) return wdata;
      return rf;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] w, input logic bp);
      bus.if_valid = v;
      bus.if_inst  = {bp, pc, w};
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      bus.kill     = 1'b0;
      bus.ex_ready = 1'b1;
      bus.wb_we    = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      set_in(1'b1, 32'h80, 32'h00500093, 1'b1);
      bus.ex_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %0h exp 0", bus.if_ready); end
      checks++;
      if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0h exp 0", bus.ex_valid); end
      checks++;
      if ({bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_rd, bus.ex_class,
           bus.ex_alu_op, bus.ex_bp_taken, bus.ex_illegal} !== '0) begin
         errors++; $display("FAIL reset_ex_fields got pc %h imm %h rd %0d exp all 0", bus.ex_pc, bus.ex_imm, bus.ex_rd);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      // reset arriving while the slot is stalled
      set_in(1'b1, 32'h84, 32'h00500093, 1'b0);
      bus.ex_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL stall_fill got %0h exp 1", bus.ex_valid); end
      reset = 1'b1;
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({bus.ex_valid, bus.ex_pc} !== 33'd0) begin
         errors++; $display("FAIL reset_mid_stall got valid %0h pc %h exp 0 0", bus.ex_valid, bus.ex_pc);
      end
      idle(1);
   endtask

   task automatic test_addi();
      bus.rf_rs1_data = 32'hA5A5A5A5;
      bus.rf_rs2_data = 32'h5A5A5A5A;
      set_in(1'b1, 32'h100, 32'h00500093, 1'b0);
      bus.ex_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.rf_rs1_addr, bus.rf_rs2_addr} !== {5'd0, 5'd5}) begin
         errors++; $display("FAIL addi_rf_addr got %0d %0d exp 0 5", bus.rf_rs1_addr, bus.rf_rs2_addr);
      end
      @(posedge clk); #1;
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h exp 1", bus.ex_valid); end
      checks++;
      if ({bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.ex_class, bus.ex_alu_op, bus.ex_rs1_val} !==
          {32'h100, 5'd1, 32'd5, 4'd0, 4'd0, 32'd0}) begin
         errors++; $display("FAIL addi_fields got pc %h rd %0d imm %h cls %0d alu %h rs1 %h exp 100 1 5 0 0 0",
                            bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.ex_class, bus.ex_alu_op, bus.ex_rs1_val);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0h exp 0", bus.ex_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] insts [0:2];
      logic [31:0] pcs   [0:2];
      logic [31:0] got;
      int idx, emitted;
      insts[0] = 32'h00100093; insts[1] = 32'h00200113; insts[2] = 32'h00300193;
      pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208;
      idx = 0; emitted = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 12; cyc++) begin
         bus.ex_ready = !(cyc == 1 || cyc == 2);
         if (idx < 3) set_in(1'b1, pcs[idx], insts[idx], 1'b0);
         else         set_in(1'b0, 32'd0, 32'd0, 1'b0);
         @(negedge clk);
         if (cyc == 1 || cyc == 2) begin
            checks++;
            if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cyc %0d got %0h exp 0", cyc, bus.if_ready); end
            checks++;
            if ({bus.ex_valid, bus.ex_pc, bus.ex_imm} !== {1'b1, 32'h200, 32'd1}) begin
               errors++; $display("FAIL b2b_stable cyc %0d got v %0h pc %h imm %h exp 1 200 1", cyc, bus.ex_valid, bus.ex_pc, bus.ex_imm);
            end
         end
         if (bus.ex_valid && bus.ex_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra got pc %h exp none", bus.ex_pc);
            end else begin
               got = exp_q.pop_front();
               if (bus.ex_pc !== got) begin errors++; $display("FAIL b2b_order got %h exp %h", bus.ex_pc, got); end
            end
            emitted++;
         end
         if (bus.if_valid && bus.if_ready) begin
            exp_q.push_back(pcs[idx]);
            idx++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (emitted != 3 || idx != 3 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_count got emitted %0d accepted %0d exp 3 3", emitted, idx);
      end
      idle(1);
   endtask

   task automatic test_load_use();
      logic [31:0] insts [0:1];
      logic [31:0] pcs   [0:1];
      logic [5:0]  vseq;
      int idx, low;
      insts[0] = 32'h00012283; insts[1] = 32'h00128333;
      pcs[0] = 32'h300; pcs[1] = 32'h304;
      idx = 0; low = 0; vseq = '0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         bus.ex_ready = 1'b1;
         if (idx < 2) set_in(1'b1, pcs[idx], insts[idx], 1'b0);
         else         set_in(1'b0, 32'd0, 32'd0, 1'b0);
         @(negedge clk);
         vseq[cyc] = bus.ex_valid;
         if (cyc == 1) begin
            checks++;
            if ({bus.ex_class, bus.ex_rd, bus.ex_pc} !== {4'd6, 5'd5, 32'h300}) begin
               errors++; $display("FAIL lu_load got cls %0d rd %0d pc %h exp 6 5 300", bus.ex_class, bus.ex_rd, bus.ex_pc);
            end
         end
         if (cyc == 3) begin
            checks++;
            if ({bus.ex_pc, bus.ex_rd, bus.ex_class, bus.ex_alu_op} !== {32'h304, 5'd6, 4'd0, 4'd0}) begin
               errors++; $display("FAIL lu_add got pc %h rd %0d cls %0d alu %h exp 304 6 0 0", bus.ex_pc, bus.ex_rd, bus.ex_class, bus.ex_alu_op);
            end
         end
         if (idx < 2 && !bus.if_ready) low++;
         if (bus.if_valid && bus.if_ready) idx++;
         @(posedge clk); #1;
      end
      checks++;
      if (low != 1) begin errors++; $display("FAIL lu_stall_cycles got %0d exp 1", low); end
      checks++;
      if (vseq[3:1] !== 3'b101) begin errors++; $display("FAIL lu_bubble got %b exp 101", vseq[3:1]); end
      checks++;
      if (idx != 2) begin errors++; $display("FAIL lu_accepted got %0d exp 2", idx); end
      idle(1);
   endtask

   task automatic test_bypass();
      bus.rf_rs1_data = 32'h11111111;
      bus.rf_rs2_data = 32'h22222222;
      bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEADBEEF;
      bus.ex_ready = 1'b0;
      set_in(1'b1, 32'h600, 32'h000183B3, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({bus.ex_rs1_val, bus.ex_rs2_val} !== {32'hDEADBEEF, 32'd0}) begin
         errors++; $display("FAIL byp_hit got %h %h exp deadbeef 0", bus.ex_rs1_val, bus.ex_rs2_val);
      end
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      bus.wb_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      checks++;
      if (bus.ex_rs1_val !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_held got %h exp deadbeef", bus.ex_rs1_val); end
      bus.ex_ready = 1'b1;
      @(posedge clk); #1;
      bus.wb_rd = 5'd0; bus.wb_data = 32'h12345678;
      set_in(1'b1, 32'h604, 32'h00000433, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({bus.ex_rs1_val, bus.ex_rs2_val} !== 64'd0) begin
         errors++; $display("FAIL byp_x0 got %h %h exp 0 0", bus.ex_rs1_val, bus.ex_rs2_val);
      end
      bus.wb_rd = 5'd4;
      set_in(1'b1, 32'h608, 32'h002184B3, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({bus.ex_rs1_val, bus.ex_rs2_val} !== {32'h11111111, 32'h22222222}) begin
         errors++; $display("FAIL byp_miss got %h %h exp 11111111 22222222", bus.ex_rs1_val, bus.ex_rs2_val);
      end
      idle(1);
   endtask

   task automatic test_kill_bubble();
      bus.ex_ready = 1'b0;
      set_in(1'b1, 32'h700, 32'h00100093, 1'b0);
      @(posedge clk); #1;
      set_in(1'b1, 32'h704, 32'h00200113, 1'b0);
      bus.kill = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL kill_flush got %0h exp 0", bus.ex_valid); end
      bus.kill = 1'b0;
      set_in(1'b0, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL kill_no_capture got %0h exp 0", bus.ex_valid); end
      bus.ex_ready = 1'b1;
      set_in(1'b1, 32'h708, 32'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready got %0h exp 1", bus.if_ready); end
      @(posedge clk); #1;
      checks++;
      if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL bubble_issued got %0h exp 0", bus.ex_valid); end
      idle(1);
   endtask

   task automatic test_branch_illegal();
      bus.ex_ready = 1'b1;
      set_in(1'b1, 32'h500, 32'hFE000EE3, 1'b1);
      @(posedge clk); #1;
      checks++;
      if ({bus.ex_valid, bus.ex_imm, bus.ex_class, bus.ex_rd, bus.ex_bp_taken, bus.ex_illegal} !==
          {1'b1, 32'hFFFFFFFC, 4'd5, 5'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL beq_decode got v %0h imm %h cls %0d rd %0d bp %0h ill %0h exp 1 fffffffc 5 0 1 0",
                            bus.ex_valid, bus.ex_imm, bus.ex_class, bus.ex_rd, bus.ex_bp_taken, bus.ex_illegal);
      end
      set_in(1'b1, 32'h504, 32'hFFFFFFFF, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({bus.ex_valid, bus.ex_illegal, bus.ex_class, bus.ex_rd, bus.ex_pc} !== {1'b1, 1'b1, 4'd0, 5'd0, 32'h504}) begin
         errors++; $display("FAIL illegal_decode got v %0h ill %0h cls %0d rd %0d pc %h exp 1 1 0 0 504",
                            bus.ex_valid, bus.ex_illegal, bus.ex_class, bus.ex_rd, bus.ex_pc);
      end
      idle(1);
   endtask

   task automatic test_random();
      logic        m_valid;
      logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
      logic [4:0]  m_rd;
      logic [3:0]  m_cls, m_alu;
      logic        m_bp, m_ill;
      logic [31:0] w;
      tdec_t       d;
      logic        haz, exp_rdy, acc;
      int          bad_rdy, bad_out;
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0; m_cls = 0; m_alu = 0; m_bp = 0; m_ill = 0;
      bad_rdy = 0; bad_out = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         w = $urandom;
         w[6:0]   = ops[$urandom_range(0, 12)];
         w[11:7]  = 5'($urandom_range(0, 7));
         w[19:15] = 5'($urandom_range(0, 7));
         w[24:20] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) w = 32'd0;
         set_in(1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFFFFFC, w, 1'($urandom_range(0, 1)));
         bus.kill        = ($urandom_range(0, 15) == 0);
         bus.ex_ready    = ($urandom_range(0, 3) != 0);
         bus.rf_rs1_data = $urandom;
         bus.rf_rs2_data = $urandom;
         bus.wb_we       = 1'($urandom_range(0, 1));
         bus.wb_rd       = 5'($urandom_range(0, 7));
         bus.wb_data     = $urandom;
         @(negedge clk);
         d = ref_decode(w);
         haz = m_valid && (m_cls == 4'd6) && (m_rd != 0) &&
               ((d.u1 && (w[19:15] == m_rd)) || (d.u2 && (w[24:20] == m_rd)));
         exp_rdy = (!m_valid || bus.ex_ready) && !haz;
         checks++;
         if ({bus.if_ready, bus.rf_rs1_addr, bus.rf_rs2_addr} !== {exp_rdy, w[19:15], w[24:20]}) begin
            errors++; bad_rdy++;
            if (bad_rdy < 6) $display("FAIL rnd_ready cyc %0d got %0h/%0d/%0d exp %0h/%0d/%0d", cyc,
                                      bus.if_ready, bus.rf_rs1_addr, bus.rf_rs2_addr, exp_rdy, w[19:15], w[24:20]);
         end
         acc = bus.if_valid && exp_rdy && !bus.kill && (w != 32'd0);
         if (bus.kill) m_valid = 1'b0;
         else if (acc) begin
            m_valid = 1'b1;
            m_pc  = bus.if_inst[63:32];
            m_bp  = bus.if_inst[64];
            m_rs1 = ref_operand(w[19:15], bus.rf_rs1_data, bus.wb_we, bus.wb_rd, bus.wb_data);
            m_rs2 = ref_operand(w[24:20], bus.rf_rs2_data, bus.wb_we, bus.wb_rd, bus.wb_data);
            m_imm = d.imm; m_rd = d.rd; m_cls = d.cls; m_alu = d.alu; m_ill = d.ill;
         end else if (bus.ex_ready) m_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if ((bus.ex_valid !== m_valid) ||
             (m_valid && ({bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_rd, bus.ex_class,
                           bus.ex_alu_op, bus.ex_bp_taken, bus.ex_illegal} !==
                          {m_pc, m_rs1, m_rs2, m_imm, m_rd, m_cls, m_alu, m_bp, m_ill}))) begin
            errors++; bad_out++;
            if (bad_out < 6) $display("FAIL rnd_slot cyc %0d got v%0h %h %h %h %h rd%0d c%0d a%h b%0h i%0h exp v%0h %h %h %h %h rd%0d c%0d a%h b%0h i%0h",
                                      cyc, bus.ex_valid, bus.ex_pc, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_rd,
                                      bus.ex_class, bus.ex_alu_op, bus.ex_bp_taken, bus.ex_illegal,
                                      m_valid, m_pc, m_rs1, m_rs2, m_imm, m_rd, m_cls, m_alu, m_bp, m_ill);
         end
      end
      idle(1);
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.kill = 1'b0;
      bus.if_valid = 1'b0;
      bus.if_inst = '0;
      bus.rf_rs1_data = '0;
      bus.rf_rs2_data = '0;
      bus.wb_we = 1'b0;
      bus.wb_rd = '0;
      bus.wb_data = '0;
      bus.ex_ready = 1'b0;
      test_reset();
      test_addi();
      test_back_to_back();
      test_load_use();
      test_bypass();
      test_kill_bubble();
      test_branch_illegal();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
